coin_credit_accumulator: RTL and testbench

Front-end stage of the vending path. It accepts coin insertions and a product selection, accumulates credit, and checks the credit against the product price. When credit covers the selected product, it presents a stable `{product, credit}` request to the downstream vending/change stage, which computes change as credit minus price. A cancel returns the full credit through a one-cycle refund pulse.

---
 rtl/vend_pkg.sv | 39 +++
 rtl/coin_credit_accumulator.sv | 118 +++++++++++
 tb/tb_coin_credit_accumulator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending path: coin codes, coin values, product prices
// and the front-end state encoding.
package vend_pkg;

    localparam int CREDIT_W_DEFAULT = 5;

    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REQUEST = 2'd2,
        REFUND  = 2'd3
    } state_t;

    function automatic logic coin_is_valid(input logic [1:0] code);
        return (code == COIN_5) || (code == COIN_10);
    endfunction

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 4'd5;
            COIN_10: return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

    // Also used by the downstream change stage, so keep the table here only.
    function automatic logic [4:0] price(input logic [1:0] prod);
        case (prod)
            2'd0:    return 5'd5;
            2'd1:    return 5'd10;
            2'd2:    return 5'd15;
            default: return 5'd20;
        endcase
    endfunction

endpackage

// File: rtl/coin_credit_accumulator.sv
// Front-end of the vending path: accumulates coin credit, checks it against the
// selected product's price, and issues either a held vend request or a refund pulse.
module coin_credit_accumulator
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = CREDIT_W_DEFAULT,
    parameter int MAX_CREDIT = 30
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                sel_valid,
    input  logic [1:0]          sel_product,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                vend_req,
    output logic [1:0]          product,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amt
);

    state_t              r_state;
    logic                r_vendReq;
    logic [1:0]          r_product;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_coinReject;
    logic                r_refundValid;
    logic [CREDIT_W-1:0] r_refundAmt;

    // One extra bit on the sum so an over-limit coin can never wrap into a small credit.
    logic [CREDIT_W:0]   w_creditExt;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_price;
    logic                w_coinOk;
    logic                w_fits;
    logic                w_selOk;

    assign w_creditExt = {1'b0, r_credit};
    assign w_sum       = w_creditExt + (CREDIT_W+1)'(coin_value(coin_val));
    assign w_price     = (CREDIT_W+1)'(price(sel_product));
    assign w_coinOk    = coin_valid && coin_is_valid(coin_val);
    assign w_fits      = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign w_selOk     = sel_valid && (w_price <= w_creditExt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_vendReq     <= 1'b0;
            r_product     <= 2'd0;
            r_credit      <= '0;
            r_coinReject  <= 1'b0;
            r_refundValid <= 1'b0;
            r_refundAmt   <= '0;
        end else begin
            r_coinReject  <= 1'b0;
            r_refundValid <= 1'b0;
            r_refundAmt   <= '0;
            case (r_state)
                IDLE: begin
                    if (coin_valid) begin
                        if (w_coinOk) begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                            r_state  <= COLLECT;
                        end else begin
                            r_coinReject <= 1'b1;
                        end
                    end
                end
                // Cancel beats an affordable selection, which beats a coin in the same cycle.
                COLLECT: begin
                    if (cancel) begin
                        r_refundValid <= 1'b1;
                        r_refundAmt   <= r_credit;
                        r_credit      <= '0;
                        r_coinReject  <= coin_valid;
                        r_state       <= REFUND;
                    end else if (w_selOk) begin
                        r_vendReq    <= 1'b1;
                        r_product    <= sel_product;
                        r_coinReject <= coin_valid;
                        r_state      <= REQUEST;
                    end else if (coin_valid) begin
                        if (w_coinOk && w_fits) begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                        end else begin
                            r_coinReject <= 1'b1;
                        end
                    end
                end
                REQUEST: begin
                    r_coinReject <= coin_valid;
                    if (vend_ack) begin
                        r_vendReq <= 1'b0;
                        r_product <= 2'd0;
                        r_credit  <= '0;
                        r_state   <= IDLE;
                    end
                end
                REFUND: begin
                    r_coinReject <= coin_valid;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vend_req     = r_vendReq;
    assign product      = r_product;
    assign credit       = r_credit;
    assign coin_reject  = r_coinReject;
    assign refund_valid = r_refundValid;
    assign refund_amt   = r_refundAmt;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Self-checking bench for coin_credit_accumulator: directed scenarios against
// hand-derived values, then random traffic against a behavioural credit model.
module tb_coin_credit_accumulator;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       sel_valid;
    logic [1:0] sel_product;
    logic       cancel;
    logic       vend_ack;
    logic       vend_req;
    logic [1:0] product;
    logic [4:0] credit;
    logic       coin_reject;
    logic       refund_valid;
    logic [4:0] refund_amt;

    int passCount;
    int checkCount;

    // Behavioural model: credit amount plus "waiting for ack" / "refund in flight" flags.
    int  mCredit;
    int  mProduct;
    bit  mRequesting;
    bit  mRefunding;
    bit  mReject;
    bit  mRefundValid;
    int  mRefundAmt;

    coin_credit_accumulator #(.CREDIT_W(5), .MAX_CREDIT(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_product(sel_product),
        .cancel(cancel), .vend_ack(vend_ack),
        .vend_req(vend_req), .product(product), .credit(credit),
        .coin_reject(coin_reject), .refund_valid(refund_valid), .refund_amt(refund_amt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mCredit = 0; mProduct = 0; mRequesting = 0; mRefunding = 0;
        mReject = 0; mRefundValid = 0; mRefundAmt = 0;
    endtask

    task automatic modelStep(input bit cv, input bit [1:0] code, input bit sv,
                             input bit [1:0] sp, input bit cn, input bit ack);
        int coinAmt;
        coinAmt = (code == 2'b01) ? 5 : (code == 2'b10) ? 10 : 0;
        mReject = 0; mRefundValid = 0; mRefundAmt = 0;
        if (mRefunding) begin
            mRefunding = 0;
            mReject    = cv;
        end else if (mRequesting) begin
            mReject = cv;
            if (ack) begin
                mRequesting = 0; mCredit = 0; mProduct = 0;
            end
        end else if (mCredit == 0) begin
            if (cv) begin
                if (coinAmt != 0) mCredit = coinAmt;
                else              mReject = 1;
            end
        end else if (cn) begin
            mRefundValid = 1; mRefundAmt = mCredit; mCredit = 0;
            mRefunding = 1;   mReject = cv;
        end else if (sv && 5 * (int'(sp) + 1) <= mCredit) begin
            mRequesting = 1; mProduct = sp; mReject = cv;
        end else if (cv) begin
            if (coinAmt != 0 && mCredit + coinAmt <= 30) mCredit = mCredit + coinAmt;
            else                                         mReject = 1;
        end
    endtask

    // Called at posedge+1; applies inputs across one rising edge and returns at posedge+1.
    task automatic applyStimulus(input bit cv, input bit [1:0] code, input bit sv,
                                 input bit [1:0] sp, input bit cn, input bit ack);
        coin_valid = cv; coin_val = code; sel_valid = sv;
        sel_product = sp; cancel = cn; vend_ack = ack;
        @(posedge clk);
        modelStep(cv, code, sv, sp, cn, ack);
        #1;
        coin_valid = 0; coin_val = 0; sel_valid = 0;
        sel_product = 0; cancel = 0; vend_ack = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        coin_valid = 0; coin_val = 0; sel_valid = 0; sel_product = 0; cancel = 0; vend_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++; if ({vend_req, product, credit, coin_reject, refund_valid, refund_amt} !== 15'd0)
            $display("[TB] FAIL reset_outputs got %h exp 0", {vend_req, product, credit, coin_reject, refund_valid, refund_amt}); else passCount++;
        rst_n = 1;
        modelReset();
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        checkCount++; if (credit !== 5'd15) $display("[TB] FAIL reset_precredit got %0d exp 15", credit); else passCount++;
        #2 rst_n = 0;
        #1;
        checkCount++; if ({vend_req, product, credit, coin_reject, refund_valid, refund_amt} !== 15'd0)
            $display("[TB] FAIL reset_async got %h exp 0", {vend_req, product, credit, coin_reject, refund_valid, refund_amt}); else passCount++;
        @(posedge clk);
        #1 rst_n = 1;
        modelReset();
        checkCount++; if (refund_valid !== 1'b0) $display("[TB] FAIL reset_norefund got %0b exp 0", refund_valid); else passCount++;
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        checkCount++; if (credit !== 5'd5) $display("[TB] FAIL reset_idle_coin got %0d exp 5", credit); else passCount++;
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_purchase();
        applyStimulus(0, 0, 1, 2'd0, 1, 0);
        checkCount++; if (vend_req !== 1'b0 || refund_valid !== 1'b0)
            $display("[TB] FAIL idle_ignore got req=%0b ref=%0b exp 0 0", vend_req, refund_valid); else passCount++;
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        checkCount++; if (credit !== 5'd5) $display("[TB] FAIL purchase_c5 got %0d exp 5", credit); else passCount++;
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        checkCount++; if (credit !== 5'd15) $display("[TB] FAIL purchase_c15 got %0d exp 15", credit); else passCount++;
        applyStimulus(0, 0, 1, 2'd2, 0, 0);
        checkCount++; if ({vend_req, product, credit} !== {1'b1, 2'd2, 5'd15})
            $display("[TB] FAIL purchase_req got %0b/%0d/%0d exp 1/2/15", vend_req, product, credit); else passCount++;
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkCount++; if ({vend_req, product, credit} !== {1'b1, 2'd2, 5'd15})
            $display("[TB] FAIL purchase_hold got %0b/%0d/%0d exp 1/2/15", vend_req, product, credit); else passCount++;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkCount++; if ({vend_req, product, credit} !== 8'd0)
            $display("[TB] FAIL purchase_ack got %0b/%0d/%0d exp 0/0/0", vend_req, product, credit); else passCount++;
    endtask

    task automatic test_insufficient();
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2'd3, 0, 0);
        checkCount++; if (vend_req !== 1'b0 || credit !== 5'd5)
            $display("[TB] FAIL short_drop got req=%0b credit=%0d exp 0 5", vend_req, credit); else passCount++;
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2'd3, 0, 0);
        checkCount++; if ({vend_req, product, credit} !== {1'b1, 2'd3, 5'd20})
            $display("[TB] FAIL short_then_ok got %0b/%0d/%0d exp 1/3/20", vend_req, product, credit); else passCount++;
        applyStimulus(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        checkCount++; if (coin_reject !== 1'b1 || credit !== 5'd25)
            $display("[TB] FAIL ovf_reject got rej=%0b credit=%0d exp 1 25", coin_reject, credit); else passCount++;
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        checkCount++; if (coin_reject !== 1'b0 || credit !== 5'd30)
            $display("[TB] FAIL ovf_max got rej=%0b credit=%0d exp 0 30", coin_reject, credit); else passCount++;
        applyStimulus(1, 2'b11, 0, 0, 0, 0);
        checkCount++; if (coin_reject !== 1'b1 || credit !== 5'd30)
            $display("[TB] FAIL ovf_badcode got rej=%0b credit=%0d exp 1 30", coin_reject, credit); else passCount++;
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkCount++; if (refund_valid !== 1'b1 || refund_amt !== 5'd30)
            $display("[TB] FAIL ovf_refund got v=%0b amt=%0d exp 1 30", refund_valid, refund_amt); else passCount++;
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_cancel();
        applyStimulus(1, 2'b00, 0, 0, 0, 0);
        checkCount++; if (coin_reject !== 1'b1 || credit !== 5'd0)
            $display("[TB] FAIL idle_badcode got rej=%0b credit=%0d exp 1 0", coin_reject, credit); else passCount++;
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkCount++; if ({refund_valid, refund_amt, credit} !== {1'b1, 5'd20, 5'd0})
            $display("[TB] FAIL cancel_pulse got %0b/%0d/%0d exp 1/20/0", refund_valid, refund_amt, credit); else passCount++;
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        checkCount++; if ({refund_valid, refund_amt, credit, coin_reject} !== {1'b0, 5'd0, 5'd0, 1'b1})
            $display("[TB] FAIL cancel_after got %0b/%0d/%0d/%0b exp 0/0/0/1", refund_valid, refund_amt, credit, coin_reject); else passCount++;
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        checkCount++; if (credit !== 5'd5) $display("[TB] FAIL cancel_idle got %0d exp 5", credit); else passCount++;
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        applyStimulus(1, 2'b01, 1, 2'd1, 0, 0);
        checkCount++; if ({vend_req, product, credit, coin_reject} !== {1'b1, 2'd1, 5'd10, 1'b1})
            $display("[TB] FAIL sim_coin_sel got %0b/%0d/%0d/%0b exp 1/1/10/1", vend_req, product, credit, coin_reject); else passCount++;
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        checkCount++; if (coin_reject !== 1'b1 || credit !== 5'd10)
            $display("[TB] FAIL sim_req_coin got rej=%0b credit=%0d exp 1 10", coin_reject, credit); else passCount++;
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 2'b10, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2'd1, 1, 0);
        checkCount++; if ({refund_valid, refund_amt, vend_req} !== {1'b1, 5'd10, 1'b0})
            $display("[TB] FAIL sim_cancel_sel got %0b/%0d/%0b exp 1/10/0", refund_valid, refund_amt, vend_req); else passCount++;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 2'b01, 0, 0, 0, 0);
        applyStimulus(1, 2'b10, 1, 2'd3, 0, 0);
        checkCount++; if (vend_req !== 1'b0 || credit !== 5'd15 || coin_reject !== 1'b0)
            $display("[TB] FAIL sim_drop_coin got req=%0b credit=%0d rej=%0b exp 0 15 0", vend_req, credit, coin_reject); else passCount++;
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0));
            checkCount++;
            if (vend_req !== mRequesting || int'(product) != mProduct || int'(credit) != mCredit ||
                coin_reject !== mReject || refund_valid !== mRefundValid || int'(refund_amt) != mRefundAmt)
                $display("[TB] FAIL random_%0d got req=%0b prod=%0d cr=%0d rej=%0b rv=%0b ra=%0d exp %0b %0d %0d %0b %0b %0d",
                         i, vend_req, product, credit, coin_reject, refund_valid, refund_amt,
                         mRequesting, mProduct, mCredit, mReject, mRefundValid, mRefundAmt);
            else passCount++;
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        modelReset();
        test_reset();
        test_purchase();
        test_insufficient();
        test_overflow();
        test_cancel();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
